eth_tx_app_gen: RTL
===================

# eth_tx_app_gen

Synthesizable, parametrised traffic generator driving the application-side TX interface of `eth_tx`. It is the hardware successor of the bench-side packet send routine. It adds:
- width-generic beat slicing;
- multi-packet bursts with programmable inter-packet gap;
- an infinite mode with graceful stop;
- a deterministic, checkable payload.

It sits between a control/CSR block and `eth_tx`, for on-chip loopback, bring-up and latency measurement.

## Interface
Parameters:
- `DATA_W`, 16: application data width in bits; one of 16, 32, 64.
- `KEEP_W`, `DATA_W/8`: bytes per beat (derived).
- `LEN_W`, `$clog2(KEEP_W+1)`: beat byte-count width (derived).
- `PKT_LEN_W`, 16: packet length field width.
- `BLOCK_N`, 8: PHY block size in bytes.
- `APP_LAST_LEN_W`, `$clog2(BLOCK_N+KEEP_W+1)`: width of the last-block-next length (derived).
- `CNT_W`, 16: packet count width.
- `GAP_W`, 8: gap counter width.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `cfg_start_i` in 1: start a burst. Ignored while `busy_o`=1.
- `cfg_stop_i` in 1: request graceful stop.
- `cfg_pkt_len_i` in `PKT_LEN_W`: payload bytes per packet. Sampled on an accepted start.
- `cfg_pkt_cnt_i` in `CNT_W`: packets per burst; 0 means infinite. Sampled on an accepted start.
- `cfg_gap_i` in `GAP_W`: idle cycles between packets. Sampled on an accepted start.
- `busy_o` out 1: a burst is in progress.
- `done_o` out 1: one-cycle pulse when the burst ends.
- `sent_cnt_o` out `CNT_W`: packets completed in the current burst. Wraps at 2^`CNT_W`.
- `app_early_v_o` out 1: packet request to `eth_tx`.
- `app_ready_v_i` in 1: `eth_tx` accepts the packet header.
- `app_cancel_o` out 1: tied 0.
- `app_data_o` out `DATA_W`: payload beat.
- `app_len_o` out `LEN_W`: valid bytes in the beat.
- `app_pkt_len_o` out `PKT_LEN_W`: packet length, held from REQ through LAST.
- `app_cs_o` out 16: tied 0.
- `app_last_o` out 1: final beat of the packet.
- `app_last_block_next_o` out 1: the next PHY block holds the packet end.
- `app_last_block_next_len_o` out `APP_LAST_LEN_W`: byte count of that block.

## Operation
The FSM has five states: IDLE, REQ, DATA, LAST, GAP.

- **IDLE:**
  - On `cfg_start_i` (with `cfg_stop_i`=0), latch the configuration, clear `sent_cnt_o`, reload the payload generator, and go to REQ.
  - `busy_o`=0 only in IDLE.
- **REQ:**
  - Drive `app_early_v_o`=1 and `app_pkt_len_o`=L.
  - When `app_ready_v_i`=1, go to DATA if L/`KEEP_W` > 0, otherwise go to LAST.
  - If `cfg_stop_i`=1 in REQ with `app_ready_v_i`=0, abort to IDLE and pulse `done_o`. A stop with ready high in the same cycle is deferred: the packet completes.
- **DATA:**
  - Emit L/`KEEP_W` beats, one per cycle, with `app_len_o`=`KEEP_W`. There is no backpressure.
  - Beat i has byte offset x=i·`KEEP_W`.
  - `app_last_block_next_o`=1 iff x%`BLOCK_N`==0 and x/`BLOCK_N`==L/`BLOCK_N`; in that beat `app_last_block_next_len_o`=L%`BLOCK_N`. In all other beats it is 0.
  - After the final full beat, go to LAST.
- **LAST:**
  - One cycle with `app_last_o`=1 and `app_len_o`=L%`KEEP_W`. This beat is emitted even when the remainder is 0.
  - Unused bytes of the beat are driven 0.
  - Increment `sent_cnt_o`.
  - If the burst is complete (the count is reached, or a stop is pending), go to IDLE and pulse `done_o`.
  - Otherwise go to GAP if G>0, else REQ.
- **GAP:** wait G cycles, then go to REQ. A stop pending in GAP exits to IDLE and pulses `done_o`.
- **Stop handling:** `cfg_stop_i` is sticky until the burst ends. It applies to finite and infinite bursts.
- **Payload (default):** byte k of packet p = (p[7:0] + k[7:0]) mod 256, in little-endian byte lanes, with p = `sent_cnt_o` at packet start.
- **Outputs outside their states:** all `app_*` outputs are 0 outside the states that drive them.

## Timing
- **Reset values:** every output is 0 and the state is IDLE on the first edge with `reset`=1. A reset mid-packet truncates the packet with no LAST beat.
- **Start to request:** `cfg_start_i` at edge n gives `app_early_v_o`=1 from cycle n+1.
- **Request to data:** `app_ready_v_i` sampled high at edge m puts the first DATA (or LAST) beat in cycle m+1.
- **Packet duration:** a packet occupies floor(L/`KEEP_W`)+1 data-side cycles. Back-to-back packets with G=0 add one REQ cycle minimum.
- **Done timing:** `done_o` is asserted in the cycle after the final LAST (or after the abort), coincident with `busy_o` falling.
- **Start coincident with done:** this start is ignored.

## Configuration
- `ETH_TX_APP_GEN_PRBS_EN`:
  - Defined: payload comes from a PRBS-31 (x^31+x^28+1) generator advancing `DATA_W` bits per DATA/LAST beat. It is seeded to 31'h7FFFFFFF on reset and on an accepted start, and continues across packets. Masked bytes are still 0.
  - Undefined: the incrementing pattern is used and no PRBS logic exists.

## Test plan
- `DATA_W`=16, L=20, N=1, G=0:
  - REQ held until ready.
  - 10 DATA beats of len 2, with `app_last_block_next_o` only at beat 8, len 4.
  - LAST with `app_len_o`=0.
  - `done_o` pulse, then `sent_cnt_o`=1.
- L=21: 10 full beats, last_block_next at beat 8 with len 5, LAST `app_len_o`=1 with data[15:8]=0.
- L=5: last_block_next at beat 0 with len 5, 2 DATA beats, LAST `app_len_o`=1. Payload bytes 00..04 for p=0.
- N=3, G=4, ready always 1: exactly 4 idle cycles between each LAST and the next REQ, payload start bytes 00/01/02, `sent_cnt_o`=3.
- N=0 (infinite) with stop pulsed mid-DATA: the current packet completes, then IDLE and `done_o`. Stop during REQ with ready=0 gives an immediate abort.
- Reset asserted mid-DATA: all outputs are 0 the next cycle. A new start then works normally; under PRBS_EN the first beat equals the reseeded value.

Source files
------------

// File: rtl/eth_tx_app_gen_if.sv
// Application-side TX bundle between eth_tx_app_gen (master) and eth_tx (slave).
// Derived widths follow DATA_W and BLOCK_N so both ends agree by construction.
interface eth_tx_app_gen_if #(
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned PKT_LEN_W      = 16,
  parameter int unsigned BLOCK_N        = 8,
  parameter int unsigned KEEP_W         = DATA_W / 8,
  parameter int unsigned LEN_W          = $clog2(KEEP_W + 1),
  parameter int unsigned APP_LAST_LEN_W = $clog2(BLOCK_N + KEEP_W + 1)
);
  logic                      app_early_v_o;
  logic                      app_ready_v_i;
  logic                      app_cancel_o;
  logic [DATA_W-1:0]         app_data_o;
  logic [LEN_W-1:0]          app_len_o;
  logic [PKT_LEN_W-1:0]      app_pkt_len_o;
  logic [15:0]               app_cs_o;
  logic                      app_last_o;
  logic                      app_last_block_next_o;
  logic [APP_LAST_LEN_W-1:0] app_last_block_next_len_o;

  modport master (
    output app_early_v_o, app_cancel_o, app_data_o, app_len_o, app_pkt_len_o, app_cs_o,
           app_last_o, app_last_block_next_o, app_last_block_next_len_o,
    input  app_ready_v_i
  );

  modport slave (
    input  app_early_v_o, app_cancel_o, app_data_o, app_len_o, app_pkt_len_o, app_cs_o,
           app_last_o, app_last_block_next_o, app_last_block_next_len_o,
    output app_ready_v_i
  );
endinterface

// File: rtl/eth_tx_app_gen.sv
// Burst traffic generator for the eth_tx application interface.
// Define ETH_TX_APP_GEN_PRBS_EN to replace the incrementing payload with PRBS-31.
module eth_tx_app_gen #(
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned KEEP_W         = DATA_W / 8,
  parameter int unsigned LEN_W          = $clog2(KEEP_W + 1),
  parameter int unsigned PKT_LEN_W      = 16,
  parameter int unsigned BLOCK_N        = 8,
  parameter int unsigned APP_LAST_LEN_W = $clog2(BLOCK_N + KEEP_W + 1),
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned GAP_W          = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_start_i,
  input  logic                 cfg_stop_i,
  input  logic [PKT_LEN_W-1:0] cfg_pkt_len_i,
  input  logic [CNT_W-1:0]     cfg_pkt_cnt_i,
  input  logic [GAP_W-1:0]     cfg_gap_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_W-1:0]     sent_cnt_o,
  eth_tx_app_gen_if.master     app
);
  localparam logic [PKT_LEN_W-1:0] KeepL  = PKT_LEN_W'(KEEP_W);
  localparam logic [PKT_LEN_W-1:0] BlockL = PKT_LEN_W'(BLOCK_N);

  typedef enum logic [2:0] {StIdle, StReq, StData, StLast, StGap} state_e;
  state_e state_q, state_d;

  logic [PKT_LEN_W-1:0] len_q, len_d, beat_q, beat_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d, sent_cnt_q, sent_cnt_d, sent_inc;
  logic [GAP_W-1:0]     gap_q, gap_d, gap_cnt_q, gap_cnt_d;
  logic                 stop_q, stop_d, done_q, done_d;
  logic                 stop_pend, start_ok, last_pkt;
  logic [PKT_LEN_W-1:0] n_beats, offset;
  logic [LEN_W-1:0]     rem_len, n_valid;
  logic [DATA_W-1:0]    raw_word, payload;

  assign n_beats   = len_q / KeepL;
  assign rem_len   = LEN_W'(len_q % KeepL);
  assign stop_pend = stop_q | cfg_stop_i;
  // A start landing on the done pulse is dropped so a burst never restarts unseen.
  assign start_ok  = cfg_start_i & ~cfg_stop_i & ~done_q;
  assign sent_inc  = sent_cnt_q + CNT_W'(1);
  assign last_pkt  = (cnt_q != '0) && (sent_inc == cnt_q);

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (start_ok) state_d = StReq;
      StReq: begin
        if (app.app_ready_v_i) state_d = (n_beats != '0) ? StData : StLast;
        else if (cfg_stop_i)   state_d = StIdle;
      end
      StData: if (beat_q == n_beats - PKT_LEN_W'(1)) state_d = StLast;
      StLast: begin
        if (last_pkt || stop_pend) state_d = StIdle;
        else if (gap_q != '0)      state_d = StGap;
        else                       state_d = StReq;
      end
      StGap: begin
        if (stop_pend)              state_d = StIdle;
        else if (gap_cnt_q == '0)   state_d = StReq;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    len_d      = len_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    sent_cnt_d = sent_cnt_q;
    beat_d     = beat_q;
    gap_cnt_d  = gap_cnt_q;
    stop_d     = 1'b0;
    done_d     = (state_q != StIdle) && (state_d == StIdle);
    if (state_q != StIdle && state_d != StIdle) stop_d = stop_pend;
    case (state_q)
      StIdle: begin
        if (start_ok) begin
          len_d      = cfg_pkt_len_i;
          cnt_d      = cfg_pkt_cnt_i;
          gap_d      = cfg_gap_i;
          sent_cnt_d = '0;
        end
      end
      StReq:  beat_d = '0;
      StData: beat_d = beat_q + PKT_LEN_W'(1);
      StLast: begin
        sent_cnt_d = sent_inc;
        gap_cnt_d  = gap_q - GAP_W'(1);
      end
      StGap:  gap_cnt_d = gap_cnt_q - GAP_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_q      <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
      sent_cnt_q <= '0;
      beat_q     <= '0;
      gap_cnt_q  <= '0;
      stop_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      sent_cnt_q <= sent_cnt_d;
      beat_q     <= beat_d;
      gap_cnt_q  <= gap_cnt_d;
      stop_q     <= stop_d;
      done_q     <= done_d;
    end
  end

`ifdef ETH_TX_APP_GEN_PRBS_EN
  // x^31 + x^28 + 1, DATA_W bits per beat, bit 0 of the beat generated first.
  logic [30:0] prbs_q, prbs_d, prbs_adv;
  always_comb begin
    logic fb;
    prbs_adv = prbs_q;
    raw_word = '0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      fb          = prbs_adv[30] ^ prbs_adv[27];
      raw_word[i] = fb;
      prbs_adv    = {prbs_adv[29:0], fb};
    end
    prbs_d = prbs_q;
    if (state_q == StIdle && start_ok)            prbs_d = 31'h7FFF_FFFF;
    else if (state_q == StData || state_q == StLast) prbs_d = prbs_adv;
  end

  always_ff @(posedge clk) begin
    if (reset) prbs_q <= 31'h7FFF_FFFF;
    else       prbs_q <= prbs_d;
  end
`else
  always_comb begin
    raw_word = '0;
    for (int j = 0; j < int'(KEEP_W); j++) begin
      raw_word[8*j +: 8] = sent_cnt_q[7:0] + offset[7:0] + 8'(j);
    end
  end
`endif

  always_comb begin
    offset  = (state_q == StLast) ? n_beats * KeepL : beat_q * KeepL;
    n_valid = (state_q == StLast) ? rem_len : LEN_W'(KEEP_W);
    payload = '0;
    for (int j = 0; j < int'(KEEP_W); j++) begin
      if (LEN_W'(j) < n_valid) payload[8*j +: 8] = raw_word[8*j +: 8];
    end
  end

  always_comb begin
    app.app_early_v_o             = 1'b0;
    app.app_cancel_o              = 1'b0;
    app.app_data_o                = '0;
    app.app_len_o                 = '0;
    app.app_pkt_len_o             = '0;
    app.app_cs_o                  = '0;
    app.app_last_o                = 1'b0;
    app.app_last_block_next_o     = 1'b0;
    app.app_last_block_next_len_o = '0;
    case (state_q)
      StReq: begin
        app.app_early_v_o = 1'b1;
        app.app_pkt_len_o = len_q;
      end
      StData: begin
        app.app_data_o    = payload;
        app.app_len_o     = LEN_W'(KEEP_W);
        app.app_pkt_len_o = len_q;
        if ((offset % BlockL) == '0 && (offset / BlockL) == (len_q / BlockL)) begin
          app.app_last_block_next_o     = 1'b1;
          app.app_last_block_next_len_o = APP_LAST_LEN_W'(len_q % BlockL);
        end
      end
      StLast: begin
        app.app_data_o    = payload;
        app.app_len_o     = rem_len;
        app.app_pkt_len_o = len_q;
        app.app_last_o    = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy_o     = (state_q != StIdle);
  assign done_o     = done_q;
  assign sent_cnt_o = sent_cnt_q;
endmodule
